seq_shift_add_mult: RTL and testbench

Sequential unsigned N x N multiplier built on the team's N-bit adder library. It consumes one adder per step in a shift-and-add loop and produces a 2N-bit product after N iterations. A start/busy/done handshake controls it. It is the first multi-cycle consumer of the adder family, and it exercises the adder under real data sequences rather than static vectors.

---
 rtl/seq_shift_add_mult.sv | 152 +++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | seq_shift_add_mult : sequential unsigned N x N shift-and-add multiplier     |
// |                      plus the Kogge-Stone prefix_adder it iterates on.      |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+

module prefix_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);
  // Group generate/propagate only span bits 0..N-2; bit N-1 needs no carry-out.
  localparam int M      = N - 1;
  localparam int LEVELS = (M > 1) ? $clog2(M) : 1;

  logic [N-1:0] h;
  logic [N-1:0] c;
  logic [M-1:0] g0;
  logic [M-1:0] p0;
  logic [M-1:0] gf;
  logic [M-1:0] pf;

  assign h  = a ^ b;
  assign g0 = a[M-1:0] & b[M-1:0];
  assign p0 = h[M-1:0];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    logic [M-1:0] gin;
    logic [M-1:0] pin;
    logic [M-1:0] gout;
    logic [M-1:0] pout;
    if (l == 0) begin : g_first
      assign gin = g0;
      assign pin = p0;
    end else begin : g_next
      assign gin = g_lvl[l-1].gout;
      assign pin = g_lvl[l-1].pout;
    end
    for (genvar i = 0; i < M; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign gout[i] = gin[i] | (pin[i] & gin[i-(1<<l)]);
        assign pout[i] = pin[i] & pin[i-(1<<l)];
      end else begin : g_pass
        assign gout[i] = gin[i];
        assign pout[i] = pin[i];
      end
    end
  end

  assign gf   = g_lvl[LEVELS-1].gout;
  assign pf   = g_lvl[LEVELS-1].pout;
  assign c[0] = cin;
  for (genvar i = 1; i < N; i++) begin : g_carry
    assign c[i] = gf[i-1] | (pf[i-1] & cin);
  end
  assign sum = h ^ c;
endmodule

module seq_shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   mcand, mcand_n;
  logic [2*N-1:0] acc, acc_n, acc_shift;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2*N-1:0] p_n;
  logic [N:0]     addend;
  logic [N:0]     step_sum;

  // Adding zero when acc[0]=0 yields the plain pass-through of the upper half.
  assign addend = acc[0] ? {1'b0, mcand} : '0;

  prefix_adder #(.N(N + 1)) u_add (
    .a   ({1'b0, acc[2*N-1:N]}),
    .b   (addend),
    .cin (1'b0),
    .sum (step_sum)
  );

  assign acc_shift = {step_sum, acc[N-1:1]};

  always_comb begin
    state_n = state;
    mcand_n = mcand;
    acc_n   = acc;
    cnt_n   = cnt;
    p_n     = p;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mcand_n = x;
          acc_n   = {{N{1'b0}}, y};
          cnt_n   = '0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        acc_n = acc_shift;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          p_n     = acc_shift;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      mcand <= mcand_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      p     <= p_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_seq_shift_add_mult : self-checking bench, N=8 plus N=16/32/64 instances  |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module tb_seq_shift_add_mult;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start8, start_w;
  logic [7:0]   x8, y8;
  logic         busy8, done8;
  logic [15:0]  p8;
  logic [15:0]  x16, y16;
  logic         busy16, done16;
  logic [31:0]  p16;
  logic [31:0]  x32, y32;
  logic         busy32, done32;
  logic [63:0]  p32;
  logic [63:0]  x64, y64;
  logic         busy64, done64;
  logic [127:0] p64;

  int total = 0;
  int bad   = 0;

  logic [15:0]  q8[$];
  logic [31:0]  q16[$];
  logic [63:0]  q32[$];
  logic [127:0] q64[$];

  seq_shift_add_mult #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .p(p8));
  seq_shift_add_mult #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .x(x16), .y(y16),
    .busy(busy16), .done(done16), .p(p16));
  seq_shift_add_mult #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .x(x32), .y(y32),
    .busy(busy32), .done(done32), .p(p32));
  seq_shift_add_mult #(.N(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .x(x64), .y(y64),
    .busy(busy64), .done(done64), .p(p64));

  // Called at a negedge; returns at the negedge where done is seen (the DONE cycle).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj,
                     output int lat, output int bcnt, output logic pchg,
                     output logic [15:0] pobs);
    logic [15:0] p0;
    p0   = p8;
    lat  = 0;
    bcnt = 0;
    pchg = 1'b0;
    pobs = 'x;
    start8 = 1'b1;
    x8 = a;
    y8 = b;
    q8.push_back(16'(a) * 16'(b));
    @(negedge clk);
    for (int n = 1; n <= 40; n++) begin
      if (busy8) bcnt++;
      if (busy8 && (p8 !== p0)) pchg = 1'b1;
      if (done8) begin
        lat  = n;
        pobs = p8;
        start8 = 1'b0;
        break;
      end
      if (n == inj) begin
        start8 = 1'b1;
        x8 = 8'd99;
        y8 = 8'd99;
      end else begin
        start8 = 1'b0;
        x8 = 8'($urandom);
        y8 = 8'($urandom);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start_w = 1'b0;
    x8 = '0; y8 = '0; x16 = '0; y16 = '0; x32 = '0; y32 = '0; x64 = '0; y64 = '0;
    #12;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done8); end
    total++; if (p8 !== 16'd0) begin bad++; $display("FAIL reset_p8: got %0d want 0", p8); end
    total++; if ({busy64, done64, p64} !== '0) begin bad++; $display("FAIL reset_n64: got busy=%b done=%b p=%0h want zeros", busy64, done64, p64); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {busy8, done8}); end
  endtask

  task automatic test_basic();
    int lat, bc; logic pc; logic [15:0] po, exp;
    op8(8'd5, 8'd10, 0, lat, bc, pc, po);
    exp = (q8.size() > 0) ? q8.pop_front() : 'x;
    total++; if (po !== exp) begin bad++; $display("FAIL basic_p: got %0d want %0d", po, exp); end
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    total++; if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    @(negedge clk);
    total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("FAIL basic_after: got busy/done %b want 00", {busy8, done8}); end
    total++; if (p8 !== exp) begin bad++; $display("FAIL basic_p_hold: got %0d want %0d", p8, exp); end
  endtask

  task automatic test_boundaries();
    logic [7:0] ta[3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] tb[3] = '{8'd255, 8'd200, 8'd200};
    int lat, bc; logic pc; logic [15:0] po, exp;
    for (int k = 0; k < 3; k++) begin
      op8(ta[k], tb[k], 0, lat, bc, pc, po);
      exp = (q8.size() > 0) ? q8.pop_front() : 'x;
      total++; if (po !== exp) begin bad++; $display("FAIL bound_p[%0d]: got %0d want %0d", k, po, exp); end
      total++; if (lat !== 9) begin bad++; $display("FAIL bound_latency[%0d]: got %0d want 9", k, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc; logic pc; logic [15:0] po, exp;
    int extra;
    op8(8'd12, 8'd13, 3, lat, bc, pc, po);
    exp = (q8.size() > 0) ? q8.pop_front() : 'x;
    total++; if (po !== exp) begin bad++; $display("FAIL ignore_p: got %0d want %0d", po, exp); end
    total++; if (pc !== 1'b0) begin bad++; $display("FAIL ignore_p_stable: p changed during RUN got %b want 0", pc); end
    total++; if (lat !== 9) begin bad++; $display("FAIL ignore_latency: got %0d want 9", lat); end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_no_second_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat1, bc1, lat2, bc2; logic pc; logic [15:0] po1, po2, e1, e2;
    op8(8'd3, 8'd7, 0, lat1, bc1, pc, po1);
    op8(8'd4, 8'd4, 0, lat2, bc2, pc, po2);
    e1 = (q8.size() > 0) ? q8.pop_front() : 'x;
    e2 = (q8.size() > 0) ? q8.pop_front() : 'x;
    total++; if (po1 !== e1) begin bad++; $display("FAIL b2b_p1: got %0d want %0d", po1, e1); end
    total++; if (lat1 !== 9) begin bad++; $display("FAIL b2b_latency1: got %0d want 9", lat1); end
    total++; if (po2 !== e2) begin bad++; $display("FAIL b2b_p2: got %0d want %0d", po2, e2); end
    total++; if (lat2 !== 9) begin bad++; $display("FAIL b2b_latency2: got %0d want 9", lat2); end
    total++; if (bc2 !== 8) begin bad++; $display("FAIL b2b_busy2: got %0d want 8", bc2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc, extra; logic pc; logic [15:0] po, exp;
    start8 = 1'b1; x8 = 8'd200; y8 = 8'd100;
    q8.push_back(16'd200 * 16'd100);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (q8.size() > 0) q8.pop_back();
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", done8); end
    total++; if (p8 !== 16'd0) begin bad++; $display("FAIL midreset_p: got %0d want 0", p8); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL midreset_quiet: got %0d active cycles want 0", extra); end
    op8(8'd6, 8'd7, 0, lat, bc, pc, po);
    exp = (q8.size() > 0) ? q8.pop_front() : 'x;
    total++; if (po !== exp) begin bad++; $display("FAIL midreset_fresh_p: got %0d want %0d", po, exp); end
    total++; if (lat !== 9) begin bad++; $display("FAIL midreset_latency: got %0d want 9", lat); end
    @(negedge clk);
  endtask

  task automatic test_wide();
    int l16, l32, l64;
    logic [31:0] o16, e16; logic [63:0] o32, e32; logic [127:0] o64, e64;
    l16 = 0; l32 = 0; l64 = 0; o16 = 'x; o32 = 'x; o64 = 'x;
    start_w = 1'b1;
    x16 = 16'd40000; y16 = 16'd50000;
    x32 = 32'hFFFF_FFFF; y32 = 32'hFFFF_FFFF;
    x64 = 64'd100000000; y64 = 64'd50000000;
    q16.push_back(32'(x16) * 32'(y16));
    q32.push_back(64'(x32) * 64'(y32));
    q64.push_back(128'(x64) * 128'(y64));
    @(negedge clk);
    start_w = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (done16 && l16 == 0) begin l16 = n; o16 = p16; end
      if (done32 && l32 == 0) begin l32 = n; o32 = p32; end
      if (done64 && l64 == 0) begin l64 = n; o64 = p64; end
      if (l16 != 0 && l32 != 0 && l64 != 0) break;
      @(negedge clk);
    end
    e16 = (q16.size() > 0) ? q16.pop_front() : 'x;
    e32 = (q32.size() > 0) ? q32.pop_front() : 'x;
    e64 = (q64.size() > 0) ? q64.pop_front() : 'x;
    total++; if (o16 !== e16) begin bad++; $display("FAIL n16_p: got %0d want %0d", o16, e16); end
    total++; if (l16 !== 17) begin bad++; $display("FAIL n16_latency: got %0d want 17", l16); end
    total++; if (o32 !== e32) begin bad++; $display("FAIL n32_p: got %0h want %0h", o32, e32); end
    total++; if (l32 !== 33) begin bad++; $display("FAIL n32_latency: got %0d want 33", l32); end
    total++; if (o64 !== e64) begin bad++; $display("FAIL n64_p: got %0d want %0d", o64, e64); end
    total++; if (l64 !== 65) begin bad++; $display("FAIL n64_latency: got %0d want 65", l64); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
